// File: rtl/sram_r_bank_responder.sv
// Bank-side responder for the SRAM read-port protocol: round-robin arbitration
// among read-port hosts, burst locking, macro drive and fixed-latency data return.
module sram_r_bank_responder #(
    parameter int PORT_CNT     = 3,
    parameter int BANK_ID      = 0,
    parameter int BANK_CNT_LG2 = 2,
    parameter int DEPTH_LG2    = 10,
    parameter int DATA_WIDTH   = 128,
    parameter int RD_LAT       = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_CNT-1:0]              req,
    input  logic [PORT_CNT*BANK_CNT_LG2-1:0] rid,
    input  logic [PORT_CNT*DEPTH_LG2-1:0]    addr,
    input  logic [PORT_CNT-1:0]              reb,
    input  logic [PORT_CNT-1:0]              rlast,
    output logic [PORT_CNT-1:0]              ack,
    output logic [PORT_CNT*DATA_WIDTH-1:0]   rdata,
    output logic [PORT_CNT-1:0]              rvalid,
    output logic                             sram_ceb,
    output logic [DEPTH_LG2-1:0]             sram_addr,
    input  logic [DATA_WIDTH-1:0]            sram_rdata,
    output logic                             busy
);

    localparam int GW = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [BANK_CNT_LG2-1:0] MY_ID = BANK_CNT_LG2'(BANK_ID);
    localparam logic [GW-1:0] LAST_PORT = GW'(PORT_CNT - 1);

    logic [0:0]           state;
    logic [GW-1:0]        gnt;
    logic [GW-1:0]        ptr;
    logic [PORT_CNT-1:0]  elig;
    logic                 found;
    logic [GW-1:0]        win;
    logic [PORT_CNT-1:0]  win_oh;
    logic                 g_req;
    logic                 g_reb;
    logic                 g_rlast;
    logic [DEPTH_LG2-1:0] g_addr;
    logic                 beat;

    logic [RD_LAT-1:0]    tag_v;
    logic [GW-1:0]        tag_g [RD_LAT];
    logic [PORT_CNT-1:0]  rvalid_d;
    logic [PORT_CNT*DATA_WIDTH-1:0] rdata_d;

    // Handshake: a host raises req with rid; ack (registered) stays high for the
    // whole burst; each cycle with req=1 and reb=0 under ack is one beat, and the
    // beat carrying rlast ends the burst. Dropping req under ack aborts it.
    always_comb begin
        for (int i = 0; i < PORT_CNT; i++) begin
            elig[i] = req[i] && (rid[i*BANK_CNT_LG2 +: BANK_CNT_LG2] == MY_ID);
        end
    end

    // First eligible port at or after ptr, wrapping to the lowest index otherwise.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            if (!found && elig[i] && (GW'(i) >= ptr)) begin
                found = 1'b1;
                win   = GW'(i);
            end
        end
        for (int i = 0; i < PORT_CNT; i++) begin
            if (!found && elig[i]) begin
                found = 1'b1;
                win   = GW'(i);
            end
        end
        for (int i = 0; i < PORT_CNT; i++) begin
            win_oh[i] = (win == GW'(i));
        end
    end

    always_comb begin
        g_req   = 1'b0;
        g_reb   = 1'b1;
        g_rlast = 1'b0;
        g_addr  = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            if (gnt == GW'(i)) begin
                g_req   = req[i];
                g_reb   = reb[i];
                g_rlast = rlast[i];
                g_addr  = addr[i*DEPTH_LG2 +: DEPTH_LG2];
            end
        end
    end

    assign beat      = (state == ST_BUSY) && g_req && !g_reb;
    assign sram_ceb  = ~beat;
    assign sram_addr = beat ? g_addr : '0;
    assign busy      = (state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= '0;
            ack   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state <= ST_BUSY;
                        gnt   <= win;
                        ptr   <= (win == LAST_PORT) ? '0 : win + GW'(1);
                        ack   <= win_oh;
                    end
                end
                ST_BUSY: begin
                    if (!g_req || (beat && g_rlast)) begin
                        state <= ST_IDLE;
                        ack   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ack   <= '0;
                end
            endcase
        end
    end

    // Each issued beat carries its port tag down a RD_LAT-deep pipe so that the
    // data lands on the originating port even after the grant has moved on.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_g[i] <= '0;
            end
        end else begin
            tag_v[0] <= beat;
            tag_g[0] <= gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_g[i] <= tag_g[i-1];
            end
        end
    end

    always_comb begin
        rvalid_d = '0;
        rdata_d  = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            if (tag_v[RD_LAT-1] && (tag_g[RD_LAT-1] == GW'(i))) begin
                rvalid_d[i] = 1'b1;
                rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = sram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= rvalid_d;
            rdata  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_r_bank_responder.sv
// Bench for sram_r_bank_responder: directed bursts plus random traffic, with a
// cycle-level reference of the arbitration rules and a queue-based data scoreboard.
module tb_sram_r_bank_responder;

    localparam int PORT_CNT     = 3;
    localparam int BANK_ID      = 1;
    localparam int BANK_CNT_LG2 = 2;
    localparam int DEPTH_LG2    = 10;
    localparam int DATA_WIDTH   = 32;
    localparam int RD_LAT       = 3;
    localparam int EW           = 32 + 8 + DATA_WIDTH;

    logic                             clk = 1'b0;
    logic                             rst;
    logic [PORT_CNT-1:0]              req;
    logic [PORT_CNT*BANK_CNT_LG2-1:0] rid;
    logic [PORT_CNT*DEPTH_LG2-1:0]    addr;
    logic [PORT_CNT-1:0]              reb;
    logic [PORT_CNT-1:0]              rlast;
    logic [PORT_CNT-1:0]              ack;
    logic [PORT_CNT*DATA_WIDTH-1:0]   rdata;
    logic [PORT_CNT-1:0]              rvalid;
    logic                             sram_ceb;
    logic [DEPTH_LG2-1:0]             sram_addr;
    logic [DATA_WIDTH-1:0]            sram_rdata;
    logic                             busy;

    sram_r_bank_responder #(
        .PORT_CNT(PORT_CNT), .BANK_ID(BANK_ID), .BANK_CNT_LG2(BANK_CNT_LG2),
        .DEPTH_LG2(DEPTH_LG2), .DATA_WIDTH(DATA_WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .rid(rid), .addr(addr), .reb(reb),
        .rlast(rlast), .ack(ack), .rdata(rdata), .rvalid(rvalid),
        .sram_ceb(sram_ceb), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
        .busy(busy)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- macro model ----------------
    function automatic logic [DATA_WIDTH-1:0] mem_word(input logic [DEPTH_LG2-1:0] a);
        return (32'(a) * 32'h9E37_79B9) ^ 32'hA5A5_0000;
    endfunction

    logic [DATA_WIDTH-1:0] mac_pipe [RD_LAT];
    always @(posedge clk) begin
        mac_pipe[0] <= sram_ceb ? 32'hDEAD_BEEF : mem_word(sram_addr);
        for (int i = 1; i < RD_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
    assign sram_rdata = mac_pipe[RD_LAT-1];

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- scoreboard: {due_cycle, port, data} ----------------
    logic [EW-1:0] exp_q[$];
    bit mon_en = 1'b0;

    always @(negedge clk) begin
        logic [PORT_CNT-1:0]            e_v;
        logic [PORT_CNT*DATA_WIDTH-1:0] e_d;
        logic [EW-1:0]                  e;
        int                             port;
        if (mon_en) begin
            e_v = '0;
            e_d = '0;
            while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
                check("rvalid_due", cyc, exp_q[0][EW-1 -: 32]);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
                e    = exp_q.pop_front();
                port = int'(e[DATA_WIDTH +: 8]);
                for (int p = 0; p < PORT_CNT; p++) begin
                    if (p == port) begin
                        e_v[p] = 1'b1;
                        e_d[p*DATA_WIDTH +: DATA_WIDTH] = e[DATA_WIDTH-1:0];
                    end
                end
            end
            check("rvalid", rvalid, e_v);
            check("rdata", rdata, e_d);
        end
    end

    // ---------------- reference arbitration state and hosts ----------------
    bit   m_busy;
    int   m_g;
    int   m_ptr;
    logic [PORT_CNT-1:0] prev_ack;
    logic [PORT_CNT-1:0] grant_log[$];

    bit               h_act   [PORT_CNT];
    logic [1:0]       h_rid   [PORT_CNT];
    logic [9:0]       h_addr  [PORT_CNT];
    int               h_left  [PORT_CNT];
    int               h_gap_at[PORT_CNT];
    int               h_gapc  [PORT_CNT];
    int               h_abort [PORT_CNT];
    int               h_life  [PORT_CNT];

    task automatic start_burst(input int p, input int r, input int a, input int len,
                               input int gap_at, input int gap_len, input int abort_at,
                               input int life);
        h_act[p]    = 1'b1;
        h_rid[p]    = 2'(r);
        h_addr[p]   = 10'(a);
        h_left[p]   = len;
        h_gap_at[p] = gap_at;
        h_gapc[p]   = gap_len;
        h_abort[p]  = abort_at;
        h_life[p]   = life;
    endtask

    // One clock cycle: check registered outputs, drive hosts, check macro drive,
    // advance the reference.
    task automatic step(input bit do_rst);
        logic [PORT_CNT-1:0]              rq, rb, rl;
        logic [PORT_CNT*DEPTH_LG2-1:0]    ad;
        logic [PORT_CNT*BANK_CNT_LG2-1:0] rd;
        logic [PORT_CNT-1:0]              exp_ack;
        logic                             exp_ceb;
        logic [DEPTH_LG2-1:0]             exp_sa;
        bit                               beat, found, sb;
        int                               sg, w;
        logic [EW-1:0]                    keep_q[$];

        @(posedge clk); #1;
        exp_ack = m_busy ? PORT_CNT'(1 << m_g) : '0;
        check("ack", ack, exp_ack);
        check("busy", busy, m_busy);
        if (ack != 0 && ack != prev_ack) grant_log.push_back(ack);
        prev_ack = ack;

        for (int i = 0; i < PORT_CNT; i++) begin
            rq[i] = h_act[i];
            rb[i] = 1'($urandom_range(0, 1));
            rl[i] = 1'($urandom_range(0, 1));
            ad[i*DEPTH_LG2 +: DEPTH_LG2] = 10'($urandom);
            rd[i*BANK_CNT_LG2 +: BANK_CNT_LG2] = h_rid[i];
            if (h_act[i] && m_busy && m_g == i) begin
                if (h_left[i] == h_abort[i]) begin
                    rq[i] = 1'b0;
                end else if (h_gap_at[i] == h_left[i] && h_gapc[i] > 0) begin
                    rb[i] = 1'b1;
                    rl[i] = 1'b1;
                end else begin
                    rb[i] = 1'b0;
                    ad[i*DEPTH_LG2 +: DEPTH_LG2] = h_addr[i];
                    rl[i] = (h_left[i] == 1);
                end
            end
        end
        if (do_rst) rq = '0;
        rst = do_rst; req = rq; reb = rb; rlast = rl; addr = ad; rid = rd;
        #1;

        sb = m_busy; sg = m_g;
        beat = 1'b0; exp_ceb = 1'b1; exp_sa = '0;
        if (do_rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            foreach (exp_q[k]) if (int'(exp_q[k][EW-1 -: 32]) <= cyc) keep_q.push_back(exp_q[k]);
            exp_q = keep_q;
            for (int i = 0; i < PORT_CNT; i++) h_act[i] = 1'b0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < PORT_CNT; k++) begin
                w = (m_ptr + k) % PORT_CNT;
                if (!found && rq[w] && rd[w*BANK_CNT_LG2 +: BANK_CNT_LG2] == BANK_ID) begin
                    found = 1'b1;
                    m_g   = w;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_ptr  = (m_g + 1) % PORT_CNT;
            end
        end else begin
            if (rq[m_g] && !rb[m_g]) begin
                beat    = 1'b1;
                exp_ceb = 1'b0;
                exp_sa  = ad[m_g*DEPTH_LG2 +: DEPTH_LG2];
                exp_q.push_back({32'(cyc + RD_LAT + 1), 8'(m_g), mem_word(exp_sa)});
            end
            if (!rq[m_g] || (beat && rl[m_g])) m_busy = 1'b0;
        end
        check("sram_ceb", sram_ceb, exp_ceb);
        check("sram_addr", sram_addr, exp_sa);

        if (!do_rst) begin
            for (int i = 0; i < PORT_CNT; i++) begin
                if (h_life[i] > 0) begin
                    h_life[i]--;
                    if (h_life[i] == 0) h_act[i] = 1'b0;
                end
            end
            if (sb && h_act[sg]) begin
                if (!rq[sg]) h_act[sg] = 1'b0;
                else if (rb[sg]) h_gapc[sg]--;
                else begin
                    h_addr[sg]++;
                    h_left[sg]--;
                    if (h_left[sg] == 0) h_act[sg] = 1'b0;
                end
            end
        end
    endtask

    function automatic bit pending();
        bit any = m_busy || (exp_q.size() > 0);
        for (int i = 0; i < PORT_CNT; i++) any = any || h_act[i];
        return any;
    endfunction

    task automatic run_until_done(input int max_cyc);
        int n = 0;
        while (pending() && n < max_cyc) begin
            step(1'b0);
            n++;
        end
        if (pending()) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout cycle=%0d got=%0d cycles expected=<%0d", cyc, n, max_cyc);
        end
    endtask

    // ---------------- main sequence ----------------
    logic [PORT_CNT-1:0] exp_order [6];

    initial begin
        int n;
        rst = 1'b1; req = '0; reb = '1; rlast = '0; addr = '0; rid = '0;
        m_busy = 1'b0; m_g = 0; m_ptr = 0; prev_ack = '0;
        for (int i = 0; i < PORT_CNT; i++) begin
            h_act[i] = 1'b0; h_rid[i] = '0; h_addr[i] = '0; h_left[i] = 0;
            h_gap_at[i] = -1; h_gapc[i] = 0; h_abort[i] = -1; h_life[i] = -1;
        end
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ceb", sram_ceb, 1);
        check("rst_sram_addr", sram_addr, 0);
        mon_en = 1'b1;

        // single 4-beat burst at 0x10
        start_burst(0, BANK_ID, 'h10, 4, -1, 0, -1, -1);
        run_until_done(100);

        // contention from reset pointer, twice
        step(1'b1);
        grant_log.delete();
        for (int p = 0; p < PORT_CNT; p++) start_burst(p, BANK_ID, 'h40 + 16 * p, 2, -1, 0, -1, -1);
        run_until_done(100);
        for (int p = 0; p < PORT_CNT; p++) start_burst(p, BANK_ID, 'h80 + 16 * p, 2, -1, 0, -1, -1);
        run_until_done(100);
        check("grant_count", grant_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < grant_log.size()) check("grant_order", grant_log[k], exp_order[k]);
        end

        // request aimed at another bank
        start_burst(1, (BANK_ID + 1) % 4, 'h20, 4, -1, 0, -1, 10);
        run_until_done(100);

        // abort after two beats, then port 0
        start_burst(2, BANK_ID, 'h100, 4, -1, 0, 2, -1);
        run_until_done(100);
        start_burst(0, BANK_ID, 'h180, 2, -1, 0, -1, -1);
        run_until_done(100);

        // reset the cycle after the last beat of a 3-beat burst
        start_burst(1, BANK_ID, 'h200, 3, -1, 0, -1, -1);
        n = 0;
        while (h_act[1] && n < 50) begin
            step(1'b0);
            n++;
        end
        step(1'b1);
        run_until_done(100);

        // two idle beats mid-burst with rlast raised during the gap
        start_burst(0, BANK_ID, 'h300, 4, 2, 2, -1, -1);
        run_until_done(100);

        // random traffic
        for (int it = 0; it < 60; it++) begin
            for (int p = 0; p < PORT_CNT; p++) begin
                if (!h_act[p] && $urandom_range(0, 2) == 0) begin
                    int len = $urandom_range(1, 5);
                    if ($urandom_range(0, 3) == 0)
                        start_burst(p, (BANK_ID + $urandom_range(1, 3)) % 4, $urandom, len,
                                    -1, 0, -1, $urandom_range(2, 6));
                    else
                        start_burst(p, BANK_ID, $urandom, len,
                                    $urandom_range(1, len), $urandom_range(0, 2),
                                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : -1, -1);
                end
            end
            repeat ($urandom_range(1, 8)) step(1'b0);
        end
        run_until_done(500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
